// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports and one synchronous write port.
// The entry at index ZREG is never written and always reads as zero.

module register_file_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = wdata_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module register_file #(
  parameter int WIDTH = 32,
  parameter int ZREG  = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra,
  input  logic [4:0]       rb,
  input  logic [4:0]       rc,
  input  logic             werf,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] radata,
  output logic [WIDTH-1:0] rbdata
);
  localparam int          NREGS = 32;
  localparam logic [4:0]  ZADDR = 5'(ZREG);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            we;

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [4:0] IDX = 5'(i);
      // werf gates the decode first so an unknown rc cannot leak into any enable
      assign we[i] = werf && (rc == IDX) && (IDX != ZADDR);

      register_file_entry #(.WIDTH(WIDTH)) u_entry (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we[i]),
        .wdata_i (wdata),
        .data_o  (regs[i])
      );
    end
  endgenerate

  assign radata = (ra == ZADDR) ? '0 : regs[ra];
  assign rbdata = (rb == ZADDR) ? '0 : regs[rb];
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, writes, zero register,
// enable gating, same-cycle read/write and asynchronous reset behaviour.

module tb_register_file;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ra, rb, rc;
  logic             werf;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] radata, rbdata;

  int total  = 0;
  int passed = 0;

  register_file #(.WIDTH(WIDTH), .ZREG(31)) dut (
    .clk    (clk),
    .reset  (reset),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .werf   (werf),
    .wdata  (wdata),
    .radata (radata),
    .rbdata (rbdata)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] addr, input logic [WIDTH-1:0] data);
    rc = addr; wdata = data; werf = 1'b1;
    @(posedge clk); #1;
    werf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; werf = 1'b0; rc = '0; wdata = '0; ra = '0; rb = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      total++;
      if (radata !== '0 || rbdata !== '0)
        $display("FAIL reset_sweep ra=%0d rb=%0d got a=%h b=%h want 0", i, 31 - i, radata, rbdata);
      else passed++;
    end
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < 31; i++) wr(5'(i), 32'hA5A50000 + 32'(i));
    for (int i = 0; i < 31; i++) begin
      ra = 5'(i); rb = 5'(i); #1;
      total++;
      if (radata !== 32'hA5A50000 + 32'(i) || rbdata !== 32'hA5A50000 + 32'(i))
        $display("FAIL write_read_all r%0d got a=%h b=%h want %h", i, radata, rbdata, 32'hA5A50000 + 32'(i));
      else passed++;
    end
  endtask

  task automatic test_zero_reg();
    wr(5'd31, 32'hFFFFFFFF);
    ra = 5'd31; rb = 5'd31; #1;
    total++;
    if (radata !== '0 || rbdata !== '0)
      $display("FAIL zero_reg got a=%h b=%h want 0", radata, rbdata);
    else passed++;
    for (int i = 0; i < 31; i++) begin
      ra = 5'(i); #1;
      total++;
      if (radata !== 32'hA5A50000 + 32'(i))
        $display("FAIL zero_reg_others r%0d got %h want %h", i, radata, 32'hA5A50000 + 32'(i));
      else passed++;
    end
  endtask

  task automatic test_enable();
    wr(5'd5, 32'h12345678);
    werf = 1'b0; rc = 5'd5; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    ra = 5'd5; #1;
    total++;
    if (radata !== 32'h12345678)
      $display("FAIL enable_gating got %h want 12345678", radata);
    else passed++;
  endtask

  task automatic test_same_cycle();
    wr(5'd7, 32'h1);
    ra = 5'd7; rb = 5'd7; rc = 5'd7; wdata = 32'h2; werf = 1'b1; #1;
    total++;
    if (radata !== 32'h1 || rbdata !== 32'h1)
      $display("FAIL same_cycle_pre got a=%h b=%h want 1", radata, rbdata);
    else passed++;
    @(posedge clk); #1;
    werf = 1'b0;
    total++;
    if (radata !== 32'h2 || rbdata !== 32'h2)
      $display("FAIL same_cycle_post got a=%h b=%h want 2", radata, rbdata);
    else passed++;
  endtask

  task automatic test_x_rc();
    werf = 1'b0; rc = 'x; wdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    rc = '0;
    ra = 5'd5; rb = 5'd7; #1;
    total++;
    if (radata !== 32'h12345678 || rbdata !== 32'h2)
      $display("FAIL x_rc got a=%h b=%h want 12345678/2", radata, rbdata);
    else passed++;
    ra = 5'd0; rb = 5'd30; #1;
    total++;
    if (radata !== 32'hA5A50000 || rbdata !== 32'hA5A5001E)
      $display("FAIL x_rc_edges got a=%h b=%h want a5a50000/a5a5001e", radata, rbdata);
    else passed++;
  endtask

  task automatic test_async_reset();
    wr(5'd3, 32'hCAFEF00D);
    ra = 5'd3; rb = 5'd5; #1;
    total++;
    if (radata !== 32'hCAFEF00D)
      $display("FAIL async_pre got %h want cafef00d", radata);
    else passed++;
    @(negedge clk);
    reset = 1'b0; #1;
    total++;
    if (radata !== '0 || rbdata !== '0)
      $display("FAIL async_reset got a=%h b=%h want 0", radata, rbdata);
    else passed++;
    // write attempted while reset is held must be ignored
    rc = 5'd9; wdata = 32'h99999999; werf = 1'b1;
    @(posedge clk); #1;
    werf = 1'b0; ra = 5'd9; #1;
    total++;
    if (radata !== '0)
      $display("FAIL write_in_reset got %h want 0", radata);
    else passed++;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    ra = 5'd3; #1;
    total++;
    if (radata !== '0)
      $display("FAIL async_post got %h want 0", radata);
    else passed++;
  endtask

  task automatic test_reset_during_write();
    rc = 5'd12; wdata = 32'h55AA55AA; werf = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; werf = 1'b0;
    ra = 5'd12; #1;
    total++;
    if (radata !== '0)
      $display("FAIL reset_wins got %h want 0", radata);
    else passed++;
    wr(5'd12, 32'h0F0F0F0F);
    total++;
    if (radata !== 32'h0F0F0F0F)
      $display("FAIL first_write_after_reset got %h want 0f0f0f0f", radata);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read_all();
    test_zero_reg();
    test_enable();
    test_same_cycle();
    test_x_rc();
    test_async_reset();
    test_reset_during_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register in bits.
REQ-002 Parameter ZREG, default 31, index of the hardwired-zero register.
REQ-003 clk  input  1  clock; all writes occur on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 ra  input  5  read address, port A.
REQ-006 rb  input  5  read address, port B.
REQ-007 rc  input  5  write address.
REQ-008 werf  input  1  write enable; active-high, sampled at the rising edge of clk.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 radata  output  WIDTH  read data, port A.
REQ-011 rbdata  output  WIDTH  read data, port B.

Function
REQ-012 Storage SHALL be 32 registers of WIDTH bits, indexed 0..31; each bit SHALL be a positive-edge flop with asynchronous active-low clear.
REQ-013 Write: at a rising clk edge with reset high, werf=1 and rc!=ZREG, register[rc] SHALL take wdata; no other register SHALL change.
REQ-014 Write with werf=0 SHALL leave all registers unchanged.
REQ-015 Write with rc==ZREG SHALL be discarded; register ZREG SHALL never hold a non-zero value.
REQ-016 Read ports SHALL be combinational, with zero-cycle latency from ra/rb to radata/rbdata.
REQ-017 radata SHALL equal 0 when ra==ZREG, otherwise register[ra]; rbdata SHALL follow the same rule with rb.
REQ-018 Write-then-read: a value written at edge N SHALL appear on a port addressing that register immediately after edge N; before edge N the port SHALL show the old value, with no bypass of wdata.
REQ-019 ra==rb SHALL drive identical values on radata and rbdata.
REQ-020 A read of the address being written in the same cycle SHALL return the pre-edge value until the edge.
REQ-021 Both ports SHALL be independent; any combination of ra, rb and rc, including all three equal, SHALL be legal.
REQ-022 X or Z on rc while werf=0 SHALL NOT corrupt any register.

Reset
REQ-023 reset low SHALL clear all 32 registers to 0 immediately, without waiting for a clk edge.
REQ-024 While reset is low, writes SHALL be ignored, and radata and rbdata SHALL read 0 for every address.
REQ-025 Reset asserted during a write cycle SHALL win; the targeted register SHALL be 0 after reset.
REQ-026 After reset deasserts, the first rising clk edge with werf=1 SHALL perform a normal write.

Verification
REQ-027 Reset then read sweep: assert reset low, release, set ra=0..31 and rb=31..0 -> radata=0 and rbdata=0 at every address.
REQ-028 Write/read all: for i=0..30 write wdata=32'hA5A50000+i to rc=i; then read ra=i -> radata=32'hA5A50000+i; rb=i -> rbdata identical.
REQ-029 Zero register: werf=1, rc=31, wdata=32'hFFFFFFFF, clock -> ra=31 gives radata=0, rb=31 gives rbdata=0, registers 0..30 unchanged.
REQ-030 Enable gating: write R5=32'h12345678; then werf=0, rc=5, wdata=32'hDEADBEEF, clock -> radata(ra=5)=32'h12345678.
REQ-031 Same-cycle read/write: ra=rb=rc=7, R7=32'h1, wdata=32'h2, werf=1 -> radata=rbdata=32'h1 before the edge and 32'h2 after it.
REQ-032 Async reset mid-operation: R3=32'hCAFEF00D; pull reset low between clk edges -> radata(ra=3)=0 within the same cycle; release reset -> R3 stays 0 until it is written again.
